// File: rtl/multicycle_cu_if.sv
// Bus bundle between the multi-cycle control unit and its
// instruction memory, register file and data memory.
interface multicycle_cu_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
);
  logic [PC_W-1:0]   imem_addr;
  logic [15:0]       imem_data;
  logic [2:0]        rf_ra_addr;
  logic [2:0]        rf_rb_addr;
  logic [DATA_W-1:0] rf_ra_data;
  logic [DATA_W-1:0] rf_rb_data;
  logic              rf_we;
  logic [2:0]        rf_wa;
  logic [DATA_W-1:0] rf_wd;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_we;
  logic              dmem_re;
  logic              dmem_ready;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output imem_addr,
    input  imem_data,
    output rf_ra_addr,
    output rf_rb_addr,
    input  rf_ra_data,
    input  rf_rb_data,
    output rf_we,
    output rf_wa,
    output rf_wd,
    output dmem_addr,
    output dmem_wdata,
    output dmem_we,
    output dmem_re,
    input  dmem_ready,
    input  dmem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  rf_ra_addr,
    input  rf_rb_addr,
    output rf_ra_data,
    output rf_rb_data,
    input  rf_we,
    input  rf_wa,
    input  rf_wd,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_we,
    input  dmem_re,
    output dmem_ready,
    output dmem_rdata
  );
endinterface

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB/WBC/HALT
// sequencer with an internal ALU for a 16-bit Harvard core.
module multicycle_cu #(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 8,
  parameter bit CARRY_TO_R0 = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  multicycle_cu_if.master bus,
  output logic [PC_W-1:0] pc_out,
  output logic [2:0]      state,
  output logic [3:0]      opcode,
  output logic            zero,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_WBC    = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_HALT = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_ST   = 4'hF;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;

  logic [3:0] op;
  logic [2:0] fn;
  logic [2:0] rd;
  logic [5:0] imm6;
  logic       is_r, is_addi, is_ld, is_st;
  logic       is_beq, is_bne, is_jmp, is_halt;
  logic       is_br, is_mem, illegal, wbc_en;

  assign op      = ir_q[15:12];
  assign fn      = ir_q[2:0];
  assign imm6    = {ir_q[11:9], ir_q[2:0]};
  assign is_r    = (op == OP_R);
  assign is_addi = (op == OP_ADDI);
  assign is_ld   = (op == OP_LD);
  assign is_st   = (op == OP_ST);
  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign is_jmp  = (op == OP_JMP);
  assign is_halt = (op == OP_HALT);
  assign is_br   = is_beq | is_bne;
  assign is_mem  = is_ld | is_st;
  assign illegal = ~(is_r | is_addi | is_mem | is_br
                   | is_jmp | is_halt);
  assign rd      = is_r ? ir_q[11:9] : ir_q[5:3];
  assign wbc_en  = CARRY_TO_R0 && is_r
                && (fn == 3'b000 || fn == 3'b001
                 || fn == 3'b101);

  // ALU: immediates force add, branches force sub
  logic [2:0]        alu_fn;
  logic [DATA_W-1:0] opb, alu_y;
  logic [DATA_W:0]   sum;
  logic              alu_c;

  always_comb begin
    opb    = (is_r || is_br) ? b_q : DATA_W'(imm6);
    alu_fn = is_r ? fn : (is_br ? 3'b001 : 3'b000);
    sum    = '0;
    alu_y  = '0;
    alu_c  = 1'b0;
    unique case (alu_fn)
      3'b000: begin
        sum   = {1'b0, a_q} + {1'b0, opb};
        alu_y = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
      end
      3'b001: begin
        sum   = {1'b0, a_q} - {1'b0, opb};
        alu_y = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
      end
      3'b010: alu_y = a_q & opb;
      3'b011: alu_y = a_q | opb;
      3'b100: alu_y = a_q ^ opb;
      3'b101: begin
        alu_y = {a_q[DATA_W-2:0], 1'b0};
        alu_c = a_q[DATA_W-1];
      end
      3'b110: alu_y = {1'b0, a_q[DATA_W-1:1]};
      3'b111: alu_y = {{(DATA_W-1){1'b0}}, a_q < opb};
    endcase
  end

  logic [PC_W-1:0] pc_inc, br_tgt;
  logic            take;

  assign pc_inc = pc_q + PC_W'(1);
  assign br_tgt = pc_inc + PC_W'({{10{imm6[5]}}, imm6});
  assign take   = is_beq ? (a_q == b_q) : (a_q != b_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_jmp, illegal: state_d = S_FETCH;
          is_halt:         state_d = S_HALT;
          default:         state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        unique case (1'b1)
          is_br:   state_d = S_FETCH;
          is_mem:  state_d = S_MEM;
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ready)
          state_d = is_ld ? S_WB : S_FETCH;
      end
      S_WB:    state_d = wbc_en ? S_WBC : S_FETCH;
      S_WBC:   state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.rf_we   = 1'b0;
    bus.rf_wa   = rd;
    bus.rf_wd   = is_ld ? mdr_q : alu_q;
    bus.dmem_we = 1'b0;
    bus.dmem_re = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      S_MEM: begin
        bus.dmem_re = is_ld;
        bus.dmem_we = is_st;
      end
      S_WB:  bus.rf_we = 1'b1;
      S_WBC: begin
        bus.rf_we = 1'b1;
        bus.rf_wa = 3'd0;
        bus.rf_wd = {{(DATA_W-1){1'b0}}, carry_q};
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    unique case (state_q)
      S_FETCH:  ir_d = bus.imem_data;
      S_DECODE: begin
        a_d = bus.rf_ra_data;
        b_d = bus.rf_rb_data;
        if (is_jmp)       pc_d = ir_q[PC_W-1:0];
        else if (illegal) pc_d = pc_inc;
      end
      S_EXEC: begin
        alu_d   = alu_y;
        zero_d  = (alu_y == '0);
        carry_d = alu_c;
        if (is_br) pc_d = take ? br_tgt : pc_inc;
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          if (is_ld) mdr_d = bus.dmem_rdata;
          else       pc_d  = pc_inc;
        end
      end
      S_WB:    pc_d = pc_inc;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.rf_ra_addr = ir_q[8:6];
  assign bus.rf_rb_addr = ir_q[5:3];
  assign bus.dmem_addr  = alu_q;
  assign bus.dmem_wdata = b_q;
  assign pc_out         = pc_q;
  assign state          = state_q;
  assign opcode         = ir_q[15:12];
  assign zero           = zero_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Bench for multicycle_cu: memories/regfile around the DUT and an
// instruction-level reference model of the ISA.
module tb_multicycle_cu;
  localparam int DW = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [PW-1:0] pc_out;
  logic [2:0]    state;
  logic [3:0]    opcode;
  logic          zero;
  logic          halted;

  multicycle_cu_if #(.DATA_W(DW), .PC_W(PW)) bus ();

  multicycle_cu #(
    .DATA_W(DW), .PC_W(PW), .CARRY_TO_R0(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .pc_out(pc_out),
    .state(state),
    .opcode(opcode),
    .zero(zero),
    .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] imem [256];
  logic [7:0]  env_rf [8];
  logic [7:0]  env_mem [256];
  int          wait_req = 0;
  int          mem_cyc = 0;

  assign bus.imem_data  = imem[bus.imem_addr];
  assign bus.rf_ra_data = env_rf[bus.rf_ra_addr];
  assign bus.rf_rb_data = env_rf[bus.rf_rb_addr];
  assign bus.dmem_ready = (mem_cyc >= wait_req);
  assign bus.dmem_rdata = env_mem[bus.dmem_addr];

  always @(posedge clk) begin
    if (bus.rf_we) env_rf[bus.rf_wa] = bus.rf_wd;
    if (bus.dmem_we && bus.dmem_ready)
      env_mem[bus.dmem_addr] = bus.dmem_wdata;
  end

  always @(posedge clk) begin
    if (state == 3'd0) mem_cyc <= 0;
    else if ((bus.dmem_re || bus.dmem_we) && !bus.dmem_ready)
      mem_cyc <= mem_cyc + 1;
  end

  logic [7:0] m_rf [8];
  logic [7:0] m_mem [256];
  int         m_pc;
  logic       m_zero;

  int checks = 0;
  int passes = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ISA-level effect of one instruction on the model state
  task automatic model(input logic [15:0] ins, input int waits,
                       output int ecyc, output int enrf,
                       output int enre, output int enwe);
    int op, ra, rb, rd, fn, imm, simm, a, b, res, c, addr;
    op   = int'(ins[15:12]);
    ra   = int'(ins[8:6]);
    rb   = int'(ins[5:3]);
    fn   = int'(ins[2:0]);
    imm  = int'({ins[11:9], ins[2:0]});
    simm = (imm >= 32) ? imm - 64 : imm;
    a    = int'(m_rf[ra]);
    b    = int'(m_rf[rb]);
    enrf = 0; enre = 0; enwe = 0; c = 0; res = 0;
    case (op)
      0: begin
        rd = int'(ins[11:9]);
        case (fn)
          0: begin res = a + b; c = (res > 255) ? 1 : 0; res = res % 256; end
          1: begin res = a - b; c = (a < b) ? 1 : 0; if (res < 0) res += 256; end
          2: res = int'(m_rf[ra] & m_rf[rb]);
          3: res = int'(m_rf[ra] | m_rf[rb]);
          4: res = int'(m_rf[ra] ^ m_rf[rb]);
          5: begin res = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
          6: res = a / 2;
          default: res = (a < b) ? 1 : 0;
        endcase
        m_rf[rd] = 8'(res);
        m_zero = (res == 0);
        enrf = 1; ecyc = 4;
        if (fn == 0 || fn == 1 || fn == 5) begin
          m_rf[0] = 8'(c);
          enrf = 2; ecyc = 5;
        end
        m_pc = (m_pc + 1) % 256;
      end
      4: begin
        res = (a + imm) % 256;
        m_rf[rb] = 8'(res);
        m_zero = (res == 0);
        enrf = 1; ecyc = 4;
        m_pc = (m_pc + 1) % 256;
      end
      11: begin
        addr = (a + imm) % 256;
        m_zero = (addr == 0);
        m_rf[rb] = m_mem[addr];
        enrf = 1; enre = waits + 1; ecyc = 5 + waits;
        m_pc = (m_pc + 1) % 256;
      end
      15: begin
        addr = (a + imm) % 256;
        m_zero = (addr == 0);
        m_mem[addr] = 8'(b);
        enwe = waits + 1; ecyc = 4 + waits;
        m_pc = (m_pc + 1) % 256;
      end
      8, 9: begin
        m_zero = (a == b);
        ecyc = 3;
        if ((op == 8) == (a == b)) m_pc = (m_pc + 1 + simm + 256) % 256;
        else m_pc = (m_pc + 1) % 256;
      end
      2: begin
        m_pc = int'(ins[7:0]);
        ecyc = 2;
      end
      default: begin
        m_pc = (m_pc + 1) % 256;
        ecyc = 2;
      end
    endcase
  endtask

  task automatic run(input logic [15:0] ins, input int waits);
    int ecyc, enrf, enre, enwe, cyc, nrf, nre, nwe, bad;
    imem[8'(m_pc)] = ins;
    wait_req = waits;
    model(ins, waits, ecyc, enrf, enre, enwe);
    cyc = 0; nrf = 0; nre = 0; nwe = 0;
    do begin
      if (bus.rf_we) nrf++;
      if (bus.dmem_re) nre++;
      if (bus.dmem_we) nwe++;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (state !== 3'd0 && cyc < 40);
    check("cycles", 32'(cyc), 32'(ecyc));
    check("pc", 32'(pc_out), 32'(m_pc));
    check("rf_writes", 32'(nrf), 32'(enrf));
    check("dmem_re_cycles", 32'(nre), 32'(enre));
    check("dmem_we_cycles", 32'(nwe), 32'(enwe));
    check("zero_flag", 32'(zero), 32'(m_zero));
    bad = 0;
    for (int i = 0; i < 8; i++) if (env_rf[i] !== m_rf[i]) bad++;
    check("regfile", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (env_mem[i] !== m_mem[i]) bad++;
    check("dmem", 32'(bad), 32'd0);
  endtask

  task automatic set_reg(input int r, input logic [7:0] v);
    env_rf[r] = v;
    m_rf[r] = v;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_pc = 0;
    m_zero = 1'b0;
  endtask

  logic [15:0] ins;
  logic [2:0]  f1, f2, f3, f4;
  logic [5:0]  im;
  logic [3:0]  ill_ops [8];
  int          nstb, k, waits;

  initial begin
    ill_ops = '{4'h1, 4'h3, 4'h5, 4'h6, 4'hA, 4'hC, 4'hD, 4'hE};
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'h0000;
      env_mem[i] = 8'($urandom);
      m_mem[i] = env_mem[i];
    end
    for (int i = 0; i < 8; i++) set_reg(i, 8'($urandom));

    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_pc", 32'(pc_out), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_strobes",
          32'({bus.rf_we, bus.dmem_we, bus.dmem_re}), 32'd0);
    reset = 1'b0;
    m_pc = 0;
    m_zero = 1'b0;

    set_reg(1, 8'd200);
    set_reg(2, 8'd100);
    run(16'h0650, 0);
    check("add_r3", 32'(env_rf[3]), 32'd44);
    check("add_carry_r0", 32'(env_rf[0]), 32'd1);

    set_reg(1, 8'h10);
    env_mem[8'h15] = 8'hA5;
    m_mem[8'h15] = 8'hA5;
    run(16'hB065, 3);
    check("ld_r4", 32'(env_rf[4]), 32'hA5);

    run(16'h2005, 0);
    set_reg(1, 8'd7);
    set_reg(2, 8'd7);
    run(16'h8E55, 0);
    check("beq_taken_pc", 32'(pc_out), 32'd3);
    run(16'h2005, 0);
    run(16'h9E55, 0);
    check("bne_not_taken_pc", 32'(pc_out), 32'd6);

    run(16'h2040, 0);
    check("jmp_pc", 32'(pc_out), 32'h40);
    run(16'h20FF, 0);
    run(16'h4069, 0);
    check("pc_wrap", 32'(pc_out), 32'd0);
    run(16'hC000, 0);
    check("illegal_skip_pc", 32'(pc_out), 32'd1);

    imem[8'(m_pc)] = 16'h7000;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("halt_state", 32'(state), 32'd6);
    check("halt_flag", 32'(halted), 32'd1);
    nstb = 0;
    repeat (20) begin
      if (bus.rf_we || bus.dmem_we || bus.dmem_re) nstb++;
      @(posedge clk);
      @(negedge clk);
    end
    check("halt_pc_frozen", 32'(pc_out), 32'(m_pc));
    check("halt_no_strobes", 32'(nstb), 32'd0);
    pulse_reset();
    check("halt_reset_pc", 32'(pc_out), 32'd0);
    check("halt_reset_flag", 32'(halted), 32'd0);

    imem[0] = 16'hF053;
    wait_req = 1000;
    nstb = 0;
    repeat (3) begin
      if (bus.rf_we) nstb++;
      @(posedge clk);
      @(negedge clk);
    end
    check("st_in_mem", 32'(state), 32'd3);
    check("st_we_high", 32'(bus.dmem_we), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_pc = 0;
    m_zero = 1'b0;
    wait_req = 0;
    check("st_abort_we", 32'(bus.dmem_we), 32'd0);
    check("st_abort_state", 32'(state), 32'd0);
    check("st_abort_pc", 32'(pc_out), 32'd0);
    check("st_abort_no_rf", 32'(nstb), 32'd0);
    nstb = 0;
    for (int i = 0; i < 256; i++) if (env_mem[i] !== m_mem[i]) nstb++;
    check("st_abort_dmem", 32'(nstb), 32'd0);

    for (int n = 0; n < 80; n++) begin
      f1 = 3'($urandom);
      f2 = 3'($urandom);
      f3 = 3'($urandom);
      f4 = 3'($urandom);
      im = 6'($urandom);
      k = int'($urandom % 8);
      waits = int'($urandom % 4);
      case (k)
        0: ins = {4'h0, f1, f2, f3, f4};
        1: ins = {4'h4, im[5:3], f2, f3, im[2:0]};
        2: ins = {4'hB, im[5:3], f2, f3, im[2:0]};
        3: ins = {4'hF, im[5:3], f2, f3, im[2:0]};
        4: ins = {4'h8, im[5:3], f2, f3, im[2:0]};
        5: ins = {4'h9, im[5:3], f2, f3, im[2:0]};
        6: ins = {4'h2, 4'h0, 8'($urandom)};
        default: ins = {ill_ops[f1], 12'($urandom)};
      endcase
      run(ins, waits);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
